// File: rtl/button_conditioner.sv
// button_conditioner: synchronise and debounce five raw push-buttons, emit edge pulses, debounced levels and an S long-press pulse.
//   clk, rst           : system clock, synchronous active-high reset
//   btn_A..btn_D       : raw asynchronous active-high buttons
//   sign_pos_*         : one-cycle pulse on accepted press
//   sign_neg_S         : one-cycle pulse on accepted release of S
//   sign_long_S        : one-cycle pulse once S has been held LONG_CYCLES
//   btn_level          : debounced levels {A,S,W,X,D}
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int LONG_CYCLES = 300000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_A,
    input  logic       btn_S,
    input  logic       btn_W,
    input  logic       btn_X,
    input  logic       btn_D,
    output logic       sign_pos_A,
    output logic       sign_pos_S,
    output logic       sign_neg_S,
    output logic       sign_pos_W,
    output logic       sign_pos_X,
    output logic       sign_pos_D,
    output logic       sign_long_S,
    output logic [4:0] btn_level
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_MAX = LW'(LONG_CYCLES - 1);
    logic [4:0] raw, s1, s2, stable, pos;
    logic [DW-1:0] cnt [5];
    logic [LW-1:0] lcnt;
    logic neg_s, long_s, long_done;
    assign raw = {btn_A, btn_S, btn_W, btn_X, btn_D};
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            stable <= '0;
            pos <= '0;
            neg_s <= 1'b0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            pos <= '0;
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == stable[i])
                    cnt[i] <= '0;
                else if (cnt[i] == D_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i] <= '0;
                    pos[i] <= s2[i];
                end else
                    cnt[i] <= cnt[i] + 1'b1;
            end
            // S release is accepted on the same edge that stable S falls
            neg_s <= stable[3] & ~s2[3] & (cnt[3] == D_MAX);
        end
    end
    // lcnt holds at terminal count so the pulse fires once per press
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt <= '0;
            long_done <= 1'b0;
            long_s <= 1'b0;
        end else begin
            long_s <= 1'b0;
            if (!stable[3]) begin
                lcnt <= '0;
                long_done <= 1'b0;
            end else if (!long_done) begin
                if (lcnt == L_MAX) begin
                    long_s <= 1'b1;
                    long_done <= 1'b1;
                end else
                    lcnt <= lcnt + 1'b1;
            end
        end
    end
    assign {sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_X, sign_pos_D} = pos;
    assign sign_neg_S = neg_s;
    assign sign_long_S = long_s;
    assign btn_level = stable;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with short debounce/long-press counts.
module tb_button_conditioner;
    localparam int DB = 4;
    localparam int LG = 10;
    localparam logic [6:0] E_A  = 7'b1000000;
    localparam logic [6:0] E_S  = 7'b0100000;
    localparam logic [6:0] E_NS = 7'b0010000;
    localparam logic [6:0] E_W  = 7'b0001000;
    localparam logic [6:0] E_X  = 7'b0000100;
    localparam logic [6:0] E_D  = 7'b0000010;
    localparam logic [6:0] E_L  = 7'b0000001;
    typedef struct {
        int c;
        logic [6:0] v;
    } ev_t;
    logic clk = 0, rst = 1;
    logic btn_A = 0, btn_S = 0, btn_W = 0, btn_X = 0, btn_D = 0;
    logic sign_pos_A, sign_pos_S, sign_neg_S, sign_pos_W, sign_pos_X, sign_pos_D, sign_long_S;
    logic [4:0] btn_level;
    logic [6:0] pulses;
    ev_t sb[$];
    ev_t e;
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int b;

    button_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
        .clk(clk), .rst(rst),
        .btn_A(btn_A), .btn_S(btn_S), .btn_W(btn_W), .btn_X(btn_X), .btn_D(btn_D),
        .sign_pos_A(sign_pos_A), .sign_pos_S(sign_pos_S), .sign_neg_S(sign_neg_S),
        .sign_pos_W(sign_pos_W), .sign_pos_X(sign_pos_X), .sign_pos_D(sign_pos_D),
        .sign_long_S(sign_long_S), .btn_level(btn_level)
    );

    assign pulses = {sign_pos_A, sign_pos_S, sign_neg_S, sign_pos_W, sign_pos_X, sign_pos_D, sign_long_S};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every nonzero pulse vector must match the next scheduled event exactly.
    always @(negedge clk) begin
        if (pulses != 7'b0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, pulses);
            end else begin
                e = sb.pop_front();
                if (e.c != cyc || e.v != pulses) begin
                    n_err++;
                    $display("FAIL pulse_event got cyc=%0d v=%b required cyc=%0d v=%b", cyc, pulses, e.c, e.v);
                end
            end
        end
    end

    task automatic push(input int c, input logic [6:0] v);
        ev_t x;
        x.c = c;
        x.v = v;
        sb.push_back(x);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_level", {27'b0, btn_level}, 32'h0);
        check("reset_pulses", {25'b0, pulses}, 32'h0);
        rst = 0;
        repeat (3) @(negedge clk);

        // Clean press on A
        b = cyc;
        btn_A = 1;
        push(b + 6, E_A);
        wait_to(b + 5);
        check("A_level_before", {31'b0, btn_level[4]}, 32'h0);
        wait_to(b + 6);
        check("A_level_after", {27'b0, btn_level}, 32'h10);
        wait_to(b + 10);
        btn_A = 0;
        wait_to(b + 20);
        check("A_level_released", {31'b0, btn_level[4]}, 32'h0);

        // Bounce on W: high 3, low 1, high 3, low 1, then low
        b = cyc;
        btn_W = 1; wait_to(b + 3);
        btn_W = 0; wait_to(b + 4);
        btn_W = 1; wait_to(b + 7);
        btn_W = 0;
        wait_to(b + 16);
        check("W_bounce_level", {31'b0, btn_level[2]}, 32'h0);
        b = cyc;
        btn_W = 1;
        push(b + 6, E_W);
        wait_to(b + 7);
        check("W_steady_level", {31'b0, btn_level[2]}, 32'h1);
        btn_W = 0;
        wait_to(b + 16);

        // Long press on S held through edge 40, then release
        b = cyc;
        btn_S = 1;
        push(b + 6, E_S);
        push(b + 16, E_L);
        wait_to(b + 40);
        check("S_long_level", {31'b0, btn_level[3]}, 32'h1);
        b = cyc;
        btn_S = 0;
        push(b + 6, E_NS);
        wait_to(b + 5);
        check("S_level_before_release", {31'b0, btn_level[3]}, 32'h1);
        wait_to(b + 6);
        check("S_level_after_release", {31'b0, btn_level[3]}, 32'h0);
        wait_to(b + 15);

        // Short S press: 8 debounced-high cycles, no long pulse
        b = cyc;
        btn_S = 1;
        push(b + 6, E_S);
        wait_to(b + 8);
        btn_S = 0;
        push(b + 14, E_NS);
        wait_to(b + 30);

        // Simultaneous X and D
        b = cyc;
        btn_X = 1;
        btn_D = 1;
        push(b + 6, E_X | E_D);
        wait_to(b + 6);
        check("XD_level", {27'b0, btn_level}, 32'h03);
        btn_X = 0;
        btn_D = 0;
        wait_to(b + 16);

        // Reset mid-press on D
        b = cyc;
        btn_D = 1;
        push(b + 6, E_D);
        wait_to(b + 8);
        check("D_level_pre_reset", {31'b0, btn_level[0]}, 32'h1);
        rst = 1;
        wait_to(b + 9);
        check("D_reset_level", {27'b0, btn_level}, 32'h0);
        check("D_reset_pulses", {25'b0, pulses}, 32'h0);
        wait_to(b + 10);
        check("D_reset_level2", {27'b0, btn_level}, 32'h0);
        rst = 0;
        push(b + 16, E_D);
        wait_to(b + 15);
        check("D_level_before_repress", {31'b0, btn_level[0]}, 32'h0);
        wait_to(b + 16);
        check("D_level_after_repress", {31'b0, btn_level[0]}, 32'h1);
        btn_D = 0;
        wait_to(b + 30);

        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_pulse got=none required cyc=%0d v=%b", e.c, e.v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
